// File: rtl/ins_seq.sv
// Instruction sequencer: owns the PC, fetches words from instruction memory and
// steps each through decode/execute. Optional fetch timeout: INS_SEQ_FETCH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | quiet, waiting for start
// FETCH  | read request at PC held until memory answers
// DECODE | one-cycle INS_valid pulse, jump select presented
// EXEC   | waiting for EX_done, then pick next PC from J
// HALT   | all-ones word fetched (or fetch timeout); done high

module ins_seq #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] IM_addr,
  output logic              IM_rd,
  input  logic [INS_W-1:0]  IM_data,
  input  logic              IM_valid,
  output logic [INS_W-1:0]  INS,
  output logic              INS_valid,
  output logic [3:0]        JMP_sel,
  input  logic              J,
  input  logic              EX_done,
  output logic [ADDR_W-1:0] PC,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [INS_W-1:0] HALT_WORD = '1;

  state_t state;

  assign IM_addr = PC;

`ifdef INS_SEQ_FETCH_TIMEOUT_EN
  // Down-counter reloaded on every FETCH entry; terminal count zero means
  // 255 cycles have passed without a memory response.
  localparam logic [7:0] TMO_LOAD = 8'd255;
  logic [7:0] tmo_cnt;
  logic       err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      PC        <= '0;
      INS       <= '0;
      IM_rd     <= 1'b0;
      INS_valid <= 1'b0;
      JMP_sel   <= 4'd0;
      done      <= 1'b0;
`ifdef INS_SEQ_FETCH_TIMEOUT_EN
      tmo_cnt   <= TMO_LOAD;
      err_q     <= 1'b0;
`endif
    end else begin
      INS_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            PC    <= '0;
            IM_rd <= 1'b1;
`ifdef INS_SEQ_FETCH_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end
        end

        S_FETCH: begin
          if (IM_valid) begin
            INS   <= IM_data;
            IM_rd <= 1'b0;
            if (IM_data == HALT_WORD) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              state     <= S_DECODE;
              INS_valid <= 1'b1;
              JMP_sel   <= IM_data[INS_W-1 -: 4];
            end
          end
`ifdef INS_SEQ_FETCH_TIMEOUT_EN
          else if (tmo_cnt == 8'd0) begin
            state <= S_HALT;
            IM_rd <= 1'b0;
            done  <= 1'b1;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
`endif
        end

        S_DECODE: begin
          state <= S_EXEC;
        end

        S_EXEC: begin
          if (EX_done) begin
            PC      <= J ? INS[ADDR_W-1:0] : PC + 1'b1;
            state   <= S_FETCH;
            IM_rd   <= 1'b1;
            JMP_sel <= 4'd0;
`ifdef INS_SEQ_FETCH_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end
        end

        S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            PC    <= '0;
            IM_rd <= 1'b1;
            done  <= 1'b0;
`ifdef INS_SEQ_FETCH_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
            err_q   <= 1'b0;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_seq.sv
// Directed bench for ins_seq: table of instructions run through fetch/decode/exec,
// plus hand sequences for halt, reset mid-execute, stale responses and fetch stall.

module tb_ins_seq;

  logic        clk = 1'b0;
  logic        rst, start, IM_valid, J, EX_done;
  logic [7:0]  IM_addr, PC;
  logic        IM_rd, INS_valid, done, err;
  logic [15:0] IM_data, INS;
  logic [3:0]  JMP_sel;

  int n_checks = 0;
  int n_err    = 0;

  ins_seq #(.ADDR_W(8), .INS_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .IM_addr(IM_addr), .IM_rd(IM_rd), .IM_data(IM_data), .IM_valid(IM_valid),
    .INS(INS), .INS_valid(INS_valid), .JMP_sel(JMP_sel), .J(J),
    .EX_done(EX_done), .PC(PC), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
    int          lat;
    bit          acz;
    logic [3:0]  sel;
    logic [7:0]  next;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Jump selector model: 0 none, 1 unconditional, 2 jump if accumulator zero.
  function automatic logic jmux(input logic [3:0] sel, input bit acz);
    case (sel)
      4'd1:    return 1'b1;
      4'd2:    return acz;
      default: return 1'b0;
    endcase
  endfunction

  // Entered with the DUT in its first FETCH cycle; leaves it in the next FETCH.
  task automatic run_instr(input vec_t v);
    chk("fetch_rd", IM_rd, 1);
    chk("fetch_addr", IM_addr, v.addr);
    chk("fetch_sel", JMP_sel, 0);
    repeat (v.lat) step();
    chk("fetch_wait_rd", IM_rd, 1);
    IM_valid = 1'b1;
    IM_data  = v.word;
    step();
    IM_valid = 1'b0;
    IM_data  = 16'h0;
    chk("dec_valid", INS_valid, 1);
    chk("dec_ins", INS, v.word);
    chk("dec_sel", JMP_sel, v.sel);
    chk("dec_rd", IM_rd, 0);
    step();
    chk("exec_valid", INS_valid, 0);
    chk("exec_sel", JMP_sel, v.sel);
    EX_done = 1'b1;
    J       = jmux(JMP_sel, v.acz);
    step();
    EX_done = 1'b0;
    J       = 1'b0;
    chk("next_pc", PC, v.next);
    chk("next_addr", IM_addr, v.next);
    chk("next_rd", IM_rd, 1);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 16'h0005, 1, 1'b0, 4'd0, 8'h01};
    vecs[1]  = '{8'h01, 16'h0007, 1, 1'b0, 4'd0, 8'h02};
    vecs[2]  = '{8'h02, 16'h0009, 1, 1'b0, 4'd0, 8'h03};
    vecs[3]  = '{8'h03, 16'h1040, 1, 1'b0, 4'd1, 8'h40};
    vecs[4]  = '{8'h40, 16'h2010, 2, 1'b0, 4'd2, 8'h41};
    vecs[5]  = '{8'h41, 16'h1040, 1, 1'b0, 4'd1, 8'h40};
    vecs[6]  = '{8'h40, 16'h2010, 3, 1'b1, 4'd2, 8'h10};
    vecs[7]  = '{8'h10, 16'h10FF, 1, 1'b0, 4'd1, 8'hFF};
    vecs[8]  = '{8'hFF, 16'h0003, 1, 1'b1, 4'd0, 8'h00};
    vecs[9]  = '{8'h00, 16'h1000, 1, 1'b0, 4'd1, 8'h00};
    vecs[10] = '{8'h00, 16'h0001, 2, 1'b0, 4'd0, 8'h01};

    rst = 1'b1; start = 1'b0; IM_valid = 1'b0; IM_data = 16'h0; J = 1'b0; EX_done = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_ins", INS, 0);
    chk("rst_err", err, 0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_pc", PC, 0);
      chk("idle_rd", IM_rd, 0);
      chk("idle_sel", JMP_sel, 0);
      chk("idle_valid", INS_valid, 0);
      chk("idle_done", done, 0);
      step();
    end

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) run_instr(vecs[i]);

    // Halt word at address 1: done rises, PC holds, no INS_valid pulse.
    chk("halt_fetch_addr", IM_addr, 8'h01);
    step();
    IM_valid = 1'b1;
    IM_data  = 16'hFFFF;
    step();
    IM_valid = 1'b0;
    IM_data  = 16'h0;
    for (int i = 0; i < 4; i++) begin
      chk("halt_done", done, 1);
      chk("halt_valid", INS_valid, 0);
      chk("halt_pc", PC, 8'h01);
      chk("halt_rd", IM_rd, 0);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_addr", IM_addr, 0);
    chk("restart_rd", IM_rd, 1);
    chk("restart_done", done, 0);

    // Reset in EXEC together with a taken jump: reset must win.
    step();
    IM_valid = 1'b1;
    IM_data  = 16'h1040;
    step();
    IM_valid = 1'b0;
    step();
    chk("pre_rst_sel", JMP_sel, 4'd1);
    EX_done = 1'b1;
    J       = 1'b1;
    rst     = 1'b1;
    step();
    EX_done = 1'b0;
    J       = 1'b0;
    rst     = 1'b0;
    chk("midrst_pc", PC, 0);
    chk("midrst_rd", IM_rd, 0);
    chk("midrst_sel", JMP_sel, 0);
    chk("midrst_ins", INS, 0);
    step();
    IM_valid = 1'b1;
    IM_data  = 16'h1234;
    step();
    IM_valid = 1'b0;
    IM_data  = 16'h0;
    step();
    chk("stale_ins", INS, 0);
    chk("stale_valid", INS_valid, 0);
    chk("stale_rd", IM_rd, 0);

    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_beats_start", IM_rd, 0);

    // Memory never answers.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("stall_entry_rd", IM_rd, 1);
`ifdef INS_SEQ_FETCH_TIMEOUT_EN
    repeat (255) step();
    chk("tmo_before_err", err, 0);
    chk("tmo_before_rd", IM_rd, 1);
    step();
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 1);
    chk("tmo_rd", IM_rd, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_err_clear", err, 0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (IM_rd !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
        chk("stall_rd", IM_rd, 1);
        chk("stall_err", err, 0);
        chk("stall_done", done, 0);
      end
      step();
    end
    chk("stall_end_rd", IM_rd, 1);
    chk("stall_end_err", err, 0);
    chk("stall_end_addr", IM_addr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
